adc_serial_model: RTL
=====================

# adc_serial_model

Parametrised, multi-channel successor to the single-channel serial ADC behavioural model. It emulates an ADS7883-style serial ADC bank clocked from the system clock: it detects the reader's `sclk` and `cs` edges, shifts out `LEAD_ZEROS` zeros followed by a `WIDTH`-bit MSB-first sample on every channel, and generates per-channel square, ramp, constant or frame-count test waveforms. It sits in the testbench and FPGA self-test path in place of the real ADC, driving the ADC reader core's `sd` input(s).

## Interface
- `WIDTH`, 12, sample bits per frame.
- `LEAD_ZEROS`, 1, zero bits shifted out before the MSB.
- `CHANNELS`, 1, number of parallel `sd` outputs sharing `sclk` and `cs`.
- `PERIOD`, 10, completed frames per half-period in square mode.
- `HIGH`, 200, square-wave high level.
- `LOW`, 0, square-wave low level.
- `RAMP_STEP`, 1, ramp increment per completed frame.
- `clk` input 1: system clock; single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `sclk` input 1: serial clock from the reader; synchronous to `clk`.
- `cs` input 1: active-high chip select; frame runs while low.
- `run` input 1: enable; low forces idle.
- `mode` input 2: 0 square, 1 ramp, 2 constant, 3 frame count.
- `const_value` input WIDTH: sample value in constant mode.
- `sd` output CHANNELS: serial data; bit c is channel c.
- `done` output 1: one-`clk` pulse per completed frame.
- `frame_count` output 16: completed frames; wraps at 65535→0.

## Operation
- Edge detect: `sclk_q` and `cs_q` registered. A fall is `sclk_q & ~sclk`, and cs falls are detected the same way. No other synchroniser.
- FSM states are IDLE, LEAD, DATA and TAIL.
- **IDLE**
  - `sd` is 0.
  - On a cs fall with `run`=1: latch every channel's sample into its shift register, clear the bit counter, and go to LEAD.
- **LEAD**
  - Each sclk fall drives `sd` to 0 and increments the counter.
  - After `LEAD_ZEROS` falls, go to DATA. If `LEAD_ZEROS`=0, go directly to DATA.
- **DATA**
  - Each sclk fall drives `sd[c]` to the shift-register MSB, then shifts left.
  - The `WIDTH`-th fall drives the LSB and moves to TAIL.
- **TAIL**
  - On the first sclk fall in TAIL, `sd` drops to 0.
  - Entering TAIL pulses `done` for 1 cycle, increments `frame_count` and advances the generator.
  - Stays in TAIL until `cs` is high, then returns to IDLE.
- `cs` high in LEAD or DATA aborts the frame:
  - Go to IDLE with `sd`=0.
  - No `done` pulse, no generator advance, no count increment.
- `run`=0 in any state forces IDLE with `sd`=0; generator and count are held.
- Generator base value `b`, WIDTH bits:
  - Square: `b` toggles HIGH↔LOW after each `PERIOD` completed frames.
  - Ramp: `b += RAMP_STEP` per frame, modulo 2^WIDTH.
  - Frame count: `b = frame_count[WIDTH-1:0]`.
- Channel c sample:
  - Constant mode: `const_value`, with no offset.
  - All other modes: `(b + c) mod 2^WIDTH`.
- A `mode` change takes effect at the next latch. The ramp accumulator and the square state both run continuously, independent of `mode`.

## Timing
- Reset values: `sd`=0, `done`=0, `frame_count`=0, state IDLE, square level HIGH, ramp 0, period counter 0.
- Asserting `rst_n` mid-frame returns to these reset values immediately, with no `done` pulse.
- Latency: `sd` updates at the first `clk` edge after `sclk` is sampled low, i.e. one cycle after the fall is visible.
- `done` is asserted on the cycle the `WIDTH`-th data bit is driven.
- The sample latch occurs in the cycle the cs fall is detected.
- `sclk` high and low phases must each be ≥2 `clk` cycles.
- A cs fall and an sclk fall in the same cycle: the latch wins, and that sclk fall is not counted.
- Frame length is `LEAD_ZEROS + WIDTH` sclk falls.

## Structure
- Package `adc_model_pkg` holds:
  - the mode encodings (`MODE_SQUARE`, `MODE_RAMP`, `MODE_CONST`, `MODE_COUNT`);
  - the FSM state encoding;
  - the counter width function.
- One sub-module, `adc_wave_gen`, holds the base generator: the square period counter, the ramp accumulator and the `advance` strobe input, and outputs `b`.
- Per-channel offset adders and shift registers live in a generate loop in the top module.

## Test plan
- **Square, first frame:** defaults, `mode`=0, 13 sclk falls → `sd` = 0 then 0000_1100_1000 (200). `done` pulses once and `frame_count`=1.
- **Square period:** `PERIOD`=2, 4 full frames → samples 200, 200, 0, 0.
- **Ramp wrap:** `WIDTH`=4, `mode`=1, 17 frames → samples 0…15, then 0. A `CHANNELS`=2 instance gives channel 1 one higher than channel 0, wrapping 15→0.
- **Abort:** `cs` raised after 5 falls → no `done` and `frame_count` unchanged. The next full frame still delivers 200.
- **Constant and run gating:** `mode`=2 with `const_value`=0xABC → both channels shift out 1010_1011_1100. Dropping `run` mid-frame gives `sd`=0 and the FSM in IDLE.
- **Reset mid-DATA:** `rst_n` pulsed low → all outputs at reset values within the same cycle. The following frame delivers HIGH (200).

Source files
------------

// File: rtl/adc_model_pkg.sv
// Shared encodings for the serial ADC bank model: waveform modes, frame FSM
// states and the helper that sizes its counters.
package adc_model_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_CONST  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  // Bits needed to count 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_wave_gen.sv
// Base test-waveform generator. Square and ramp state advance once per completed
// frame regardless of mode, so switching mode never resets their phase.
module adc_wave_gen
  import adc_model_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int PERIOD    = 10,
  parameter int HIGH      = 200,
  parameter int LOW       = 0,
  parameter int RAMP_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] b
);

  localparam int PW = cnt_width(PERIOD);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HIGH);
  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LOW);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(RAMP_STEP);
  localparam logic [PW-1:0]    PLAST = PW'(PERIOD - 1);

  logic             level_high;
  logic [PW-1:0]    pcnt;
  logic [WIDTH-1:0] ramp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_high <= 1'b1;
      pcnt       <= '0;
      ramp       <= '0;
    end else if (advance) begin
      ramp <= ramp + STEP;
      if (pcnt == PLAST) begin
        pcnt       <= '0;
        level_high <= ~level_high;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  always_comb begin
    b = level_high ? HI_V : LO_V;
    case (mode)
      MODE_RAMP:  b = ramp;
      MODE_COUNT: b = count;
      default:    b = level_high ? HI_V : LO_V;
    endcase
  end

endmodule

// File: rtl/adc_serial_model.sv
// ADS7883-style serial ADC bank model: detects reader sclk/cs edges on clk and
// shifts LEAD_ZEROS zeros then a WIDTH-bit MSB-first sample out of every channel.
module adc_serial_model
  import adc_model_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int LEAD_ZEROS = 1,
  parameter int CHANNELS   = 1,
  parameter int PERIOD     = 10,
  parameter int HIGH       = 200,
  parameter int LOW        = 0,
  parameter int RAMP_STEP  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                cs,
  input  logic                run,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    const_value,
  output logic [CHANNELS-1:0] sd,
  output logic                done,
  output logic [15:0]         frame_count
);

  localparam int CMAX = (LEAD_ZEROS > WIDTH) ? LEAD_ZEROS : WIDTH;
  localparam int CW   = cnt_width(CMAX);
  localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD_ZEROS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             sclk_q, cs_q;
  logic             sclk_fall, cs_fall;
  logic             latch, data_fall, advance, hold;
  logic [WIDTH-1:0] b;

  assign sclk_fall = sclk_q & ~sclk;
  assign cs_fall   = cs_q & ~cs;

  // In IDLE sclk is ignored, so a cs fall coinciding with an sclk fall only latches.
  assign latch     = run & (state == ST_IDLE) & cs_fall;
  assign data_fall = run & ~cs & (state == ST_DATA) & sclk_fall;
  assign advance   = data_fall & (cnt == DATA_LAST);
  assign hold      = run & ~cs & ((state == ST_DATA) | (state == ST_TAIL)) & ~sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      sclk_q <= sclk;
      cs_q   <= cs;
      done   <= advance;
      if (advance) frame_count <= frame_count + 16'd1;
      if (!run) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (cs_fall) begin
            cnt   <= '0;
            state <= (LEAD_ZEROS == 0) ? ST_DATA : ST_LEAD;
          end
          ST_LEAD: if (cs) state <= ST_IDLE;
          else if (sclk_fall) begin
            if (cnt == LEAD_LAST) begin
              cnt   <= '0;
              state <= ST_DATA;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_DATA: if (cs) state <= ST_IDLE;
          else if (sclk_fall) begin
            if (cnt == DATA_LAST) state <= ST_TAIL;
            else                  cnt   <= cnt + CW'(1);
          end
          ST_TAIL: if (cs) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  adc_wave_gen #(
    .WIDTH(WIDTH), .PERIOD(PERIOD), .HIGH(HIGH), .LOW(LOW), .RAMP_STEP(RAMP_STEP)
  ) u_gen (
    .clk(clk), .rst_n(rst_n), .advance(advance), .mode(mode),
    .count(frame_count[WIDTH-1:0]), .b(b)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] sample, shreg;
    logic             sd_r;

    assign sample = (mode == MODE_CONST) ? const_value : b + WIDTH'(c);
    assign sd[c]  = sd_r;

    // sd holds the driven bit until the next fall; everything else forces 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shreg <= '0;
        sd_r  <= 1'b0;
      end else begin
        if (latch)          shreg <= sample;
        else if (data_fall) shreg <= shreg << 1;
        if (data_fall) sd_r <= shreg[WIDTH-1];
        else if (!hold) sd_r <= 1'b0;
      end
    end
  end

endmodule
